// File: rtl/ped_req_arbiter.sv
// rtl/ped_req_arbiter.sv - pedestrian request scheduler feeding traffic_control PA/PB
module ped_req_arbiter #(
  parameter int N_BTN       = 2,
  parameter int ACK_TIMEOUT = 40,
  parameter int MAX_RETRY   = 3
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             ERR,
  input  logic [N_BTN-1:0] BTN_A,
  input  logic [N_BTN-1:0] BTN_B,
  input  logic             RA,
  input  logic             RB,
  output logic             PA,
  output logic             PB,
  output logic             PEND_A,
  output logic             PEND_B,
  output logic             FAULT
);

  typedef enum logic [2:0] {
    IDLE, ISSUE_A, ISSUE_B, WAIT_ACK_A, WAIT_ACK_B, WALK_A, WALK_B
  } state_t;

  localparam logic [7:0] TMO_LAST  = 8'(ACK_TIMEOUT - 1);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  state_t     state_q, state_d;
  logic [7:0] tmo_q, tmo_d;
  logic [2:0] retry_q, retry_d;
  logic       last_b_q, last_b_d;
  logic       hist_a_q, hist_b_q, ra_q, rb_q;
  logic       pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic       fault_q, fault_d, pa_q, pb_q;
  logic       btn_a, btn_b, press_a, press_b, fall_a, fall_b;
  logic       go_a, go_b, drop_a, drop_b;

  assign btn_a   = |BTN_A;
  assign btn_b   = |BTN_B;
  assign press_a = btn_a & ~hist_a_q;
  assign press_b = btn_b & ~hist_b_q;
  assign fall_a  = ra_q & ~RA;
  assign fall_b  = rb_q & ~RB;
  // A request whose walk ends this very cycle is already served.
  assign go_a    = pend_a_q & ~fall_a;
  assign go_b    = pend_b_q & ~fall_b;

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    retry_d  = retry_q;
    last_b_d = last_b_q;
    fault_d  = fault_q;
    drop_a   = 1'b0;
    drop_b   = 1'b0;
    case (state_q)
      IDLE: begin
        // Hold off while any walk is running; traffic_control is busy.
        if (!RA && !RB) begin
          if (go_a && (!go_b || last_b_q)) state_d = ISSUE_A;
          else if (go_b)                   state_d = ISSUE_B;
        end
      end
      ISSUE_A: begin
        tmo_d   = 8'd0;
        state_d = WAIT_ACK_A;
      end
      ISSUE_B: begin
        tmo_d   = 8'd0;
        state_d = WAIT_ACK_B;
      end
      WAIT_ACK_A: begin
        if (RA) begin
          state_d = WALK_A;
        end else if (fall_a) begin
          last_b_d = 1'b0;
          retry_d  = 3'd0;
          state_d  = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 3'd1;
            state_d = ISSUE_A;
          end else begin
            drop_a  = 1'b1;
            fault_d = 1'b1;
            retry_d = 3'd0;
            state_d = IDLE;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      WAIT_ACK_B: begin
        if (RB) begin
          state_d = WALK_B;
        end else if (fall_b) begin
          last_b_d = 1'b1;
          retry_d  = 3'd0;
          state_d  = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 3'd1;
            state_d = ISSUE_B;
          end else begin
            drop_b  = 1'b1;
            fault_d = 1'b1;
            retry_d = 3'd0;
            state_d = IDLE;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      WALK_A: begin
        if (fall_a) begin
          last_b_d = 1'b0;
          retry_d  = 3'd0;
          state_d  = IDLE;
        end
      end
      WALK_B: begin
        if (fall_b) begin
          last_b_d = 1'b1;
          retry_d  = 3'd0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A walk ending on the same edge as a press wins; that press is lost.
  always_comb begin
    pend_a_d = pend_a_q;
    pend_b_d = pend_b_q;
    if (fall_a || drop_a)    pend_a_d = 1'b0;
    else if (press_a && !RA) pend_a_d = 1'b1;
    if (fall_b || drop_b)    pend_b_d = 1'b0;
    else if (press_b && !RB) pend_b_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= IDLE;
      tmo_q    <= 8'd0;
      retry_q  <= 3'd0;
      last_b_q <= 1'b1;
      hist_a_q <= btn_a;
      hist_b_q <= btn_b;
      ra_q     <= RA;
      rb_q     <= RB;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      fault_q  <= 1'b0;
      pa_q     <= 1'b0;
      pb_q     <= 1'b0;
    end else begin
      hist_a_q <= btn_a;
      hist_b_q <= btn_b;
      ra_q     <= RA;
      rb_q     <= RB;
      if (ERR) begin
        state_q  <= IDLE;
        tmo_q    <= 8'd0;
        retry_q  <= 3'd0;
        pend_a_q <= 1'b0;
        pend_b_q <= 1'b0;
        pa_q     <= 1'b0;
        pb_q     <= 1'b0;
      end else begin
        state_q  <= state_d;
        tmo_q    <= tmo_d;
        retry_q  <= retry_d;
        last_b_q <= last_b_d;
        pend_a_q <= pend_a_d;
        pend_b_q <= pend_b_d;
        fault_q  <= fault_d;
        pa_q     <= (state_d == ISSUE_A);
        pb_q     <= (state_d == ISSUE_B);
      end
    end
  end

  assign PA     = pa_q;
  assign PB     = pb_q;
  assign PEND_A = pend_a_q;
  assign PEND_B = pend_b_q;
  assign FAULT  = fault_q;

endmodule
